seg7_scan_driver: RTL

// - Upstream feeder for the 4-digit 7-segment decoder. Holds a 4-nibble display value and

---
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Scan driver for a 4-digit 7-segment display: divides the clock, walks the digit index,
// swaps newly loaded values in only at frame boundaries and flags leading zeros for blanking.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DIGITS_IN,
    input  logic [3:0]  DOTS_IN,
    input  logic        LOAD_IN,
    input  logic        BLANK_LZ_IN,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        BLANK_OUT,
    output logic        FRAME_TICK_OUT,
    output logic        PENDING_OUT
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(REFRESH_DIV - 1);

    // Display and pending words are packed as {dots[3:0], digits[15:0]}.
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       index;
    logic [19:0]      display_reg;
    logic [19:0]      pending_reg;
    logic             pending_flag;

    logic             tick;
    logic             apply;
    logic [1:0]       next_index;
    logic [19:0]      load_word;
    logic [19:0]      display_next;
    logic [3:0]       next_bin;
    logic             next_dot;
    logic             next_blank;

    // Digit k is blank when every nibble and dot from k up to the leftmost digit is zero.
    function automatic logic lz_blank(input logic [19:0] word, input logic [1:0] k);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(k)) begin
                if (word[j*4 +: 4] != 4'h0 || word[16 + j]) begin
                    all_zero = 1'b0;
                end
            end
        end
        return (k != 2'd0) && all_zero;
    endfunction

    always_comb begin
        tick         = (div_cnt == DIV_MAX);
        apply        = tick && (index == 2'd3);
        next_index   = index + 2'd1;
        load_word    = {DOTS_IN, DIGITS_IN};
        display_next = display_reg;
        if (apply) begin
            if (LOAD_IN) begin
                display_next = load_word;
            end else if (pending_flag) begin
                display_next = pending_reg;
            end
        end
        next_bin   = display_next[next_index*4 +: 4];
        next_dot   = display_next[16 + int'(next_index)];
        next_blank = BLANK_LZ_IN && lz_blank(display_next, next_index);
    end

    // Outputs are computed from the post-apply display so digit 0 of a new frame is already current.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt        <= '0;
            index          <= 2'd0;
            display_reg    <= 20'h0;
            pending_reg    <= 20'h0;
            pending_flag   <= 1'b0;
            BIN_OUT        <= 4'h0;
            DOT_OUT        <= 1'b0;
            BLANK_OUT      <= 1'b0;
            FRAME_TICK_OUT <= 1'b0;
        end else begin
            div_cnt        <= tick ? '0 : div_cnt + 1'b1;
            FRAME_TICK_OUT <= apply;
            display_reg    <= display_next;
            if (apply) begin
                pending_flag <= 1'b0;
            end else if (LOAD_IN) begin
                pending_reg  <= load_word;
                pending_flag <= 1'b1;
            end
            if (tick) begin
                index     <= next_index;
                BIN_OUT   <= next_bin;
                DOT_OUT   <= next_dot;
                BLANK_OUT <= next_blank;
            end
        end
    end

    assign SEG_SELECT_OUT = index;
    assign PENDING_OUT    = pending_flag;

endmodule
